// File: rtl/universal_shift_register_param.sv
// WIDTH-bit universal shift register: shifts, loads, variable rotates, arithmetic
// shift right and a self-timed LSB-first burst serialiser with Busy/Valid/Done flags.
module universal_shift_register_param #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             Clk_In,
    input  logic             Reset_N_In,
    input  logic [2:0]       Mode_In,
    input  logic [AMT_W-1:0] Shift_Amount_In,
    input  logic             Serial_Data_Left_In,
    input  logic             Serial_Data_Right_In,
    input  logic [WIDTH-1:0] Parallel_Data_In,
    output logic             Serial_Data_Out,
    output logic [WIDTH-1:0] Parallel_Data_Out,
    output logic             Busy_Out,
    output logic             Serial_Valid_Out,
    output logic             Done_Out
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    localparam logic [AMT_W-1:0] LAST_BIT = AMT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [AMT_W-1:0] bit_cnt;
    logic             busy;
    logic             done;

    // Rotate right by n; index wraps modulo WIDTH.
    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v,
                                                   input logic [AMT_W-1:0] n);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = v[(i + int'(n)) % WIDTH];
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] arith_shr(input logic [WIDTH-1:0] v,
                                                   input logic [AMT_W-1:0] n);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return WIDTH'(sv >>> n);
    endfunction

    // Rotate left by n equals rotate right by (WIDTH - n) mod WIDTH; WIDTH is a power of two.
    logic [AMT_W-1:0] rotl_amt;
    assign rotl_amt = AMT_W'(0) - Shift_Amount_In;

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                if (bit_cnt != LAST_BIT) begin
                    shift_reg <= {Serial_Data_Left_In, shift_reg[WIDTH-1:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                end else begin
                    // Terminal edge: a 111 here chains the next word with no idle gap.
                    done <= 1'b1;
                    if (Mode_In == MODE_BURST) begin
                        shift_reg <= Parallel_Data_In;
                        bit_cnt   <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
            end else begin
                case (Mode_In)
                    MODE_HOLD: shift_reg <= shift_reg;
                    MODE_SHR:  shift_reg <= {Serial_Data_Left_In, shift_reg[WIDTH-1:1]};
                    MODE_SHL:  shift_reg <= {shift_reg[WIDTH-2:0], Serial_Data_Right_In};
                    MODE_LOAD: shift_reg <= Parallel_Data_In;
                    MODE_ROTR: shift_reg <= rot_right(shift_reg, Shift_Amount_In);
                    MODE_ROTL: shift_reg <= rot_right(shift_reg, rotl_amt);
                    MODE_ASR:  shift_reg <= arith_shr(shift_reg, Shift_Amount_In);
                    default: begin
                        shift_reg <= Parallel_Data_In;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign Serial_Data_Out   = shift_reg[0];
    assign Parallel_Data_Out = shift_reg;
    assign Busy_Out          = busy;
    assign Serial_Valid_Out  = busy;
    assign Done_Out          = done;

endmodule

// File: tb/tb_universal_shift_register_param.sv
// Scoreboard bench for universal_shift_register_param at WIDTH=8.
module tb_universal_shift_register_param;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [2:0]       mode = 3'b000;
    logic [AMT_W-1:0] amt = '0;
    logic             left_in = 1'b0;
    logic             right_in = 1'b0;
    logic [WIDTH-1:0] pdata = '0;
    logic             sdo;
    logic [WIDTH-1:0] pdo;
    logic             busy;
    logic             valid;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             bit_q[$];

    universal_shift_register_param #(.WIDTH(WIDTH)) dut (
        .Clk_In               (clk),
        .Reset_N_In           (rst_n),
        .Mode_In              (mode),
        .Shift_Amount_In      (amt),
        .Serial_Data_Left_In  (left_in),
        .Serial_Data_Right_In (right_in),
        .Parallel_Data_In     (pdata),
        .Serial_Data_Out      (sdo),
        .Parallel_Data_Out    (pdo),
        .Busy_Out             (busy),
        .Serial_Valid_Out     (valid),
        .Done_Out             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic [2:0] m, input logic [AMT_W-1:0] a,
                        input logic l, input logic r, input logic [WIDTH-1:0] pd);
        @(negedge clk);
        mode = m; amt = a; left_in = l; right_in = r; pdata = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_word(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(pdo), 32'(e));
        end
    endtask

    task automatic pop_bit(input string tag);
        logic e;
        if (bit_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = bit_q.pop_front();
            chk(tag, 32'(sdo), 32'(e));
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        exp_q.push_back(v);
        step(3'b011, 3'd0, 1'b0, 1'b0, v);
        pop_word("load");
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int               mcnt;

        // Asynchronous reset in mid-cycle, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pdo",   32'(pdo),   32'h0);
        chk("rst_sdo",   32'(sdo),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_done",  32'(done),  32'h0);
        #19 rst_n = 1'b1;

        load(8'hA5);
        chk("load_sdo", 32'(sdo), 32'h1);

        exp_q.push_back(8'hD2);
        step(3'b001, 3'd5, 1'b1, 1'b0, 8'h00);
        pop_word("shr");

        load(8'hA5);
        exp_q.push_back(8'h4A);
        step(3'b010, 3'd6, 1'b1, 1'b0, 8'hFF);
        pop_word("shl");

        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h4A);
            step(3'b000, 3'd7, 1'b1, 1'b1, 8'h33);
            pop_word("hold");
        end

        load(8'hA5);
        exp_q.push_back(8'hB4);
        step(3'b100, 3'd3, 1'b0, 1'b0, 8'h00);
        pop_word("rotr3");

        load(8'hA5);
        exp_q.push_back(8'h5A);
        step(3'b101, 3'd4, 1'b0, 1'b0, 8'h00);
        pop_word("rotl4");

        load(8'hA5);
        exp_q.push_back(8'hA5);
        step(3'b100, 3'd0, 1'b1, 1'b1, 8'h00);
        pop_word("rotr0");

        exp_q.push_back(8'hD2);
        step(3'b101, 3'd7, 1'b0, 1'b0, 8'h00);
        pop_word("rotl7");

        load(8'hA5);
        exp_q.push_back(8'hE9);
        step(3'b110, 3'd2, 1'b0, 1'b0, 8'h00);
        pop_word("asr2_neg");

        load(8'h25);
        exp_q.push_back(8'h09);
        step(3'b110, 3'd2, 1'b1, 1'b1, 8'h00);
        pop_word("asr2_pos");
        chk("idle_busy", 32'(busy), 32'h0);

        // Burst 0x96 with random Mode_In traffic; 111 withheld from the terminal edge
        w = 8'h96;
        for (int k = 0; k < WIDTH; k++) bit_q.push_back(w[k]);
        step(3'b111, 3'd0, 1'b0, 1'b0, w);
        for (int k = 0; k < WIDTH; k++) begin
            chk("b1_valid", 32'(valid), 32'h1);
            chk("b1_busy",  32'(busy),  32'h1);
            chk("b1_done",  32'(done),  32'h0);
            pop_bit("b1_sdo");
            mcnt = (k == WIDTH - 1) ? $urandom_range(0, 6) : $urandom_range(0, 7);
            step(3'(mcnt), 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end
        chk("b1_done_pulse", 32'(done),  32'h1);
        chk("b1_busy_end",   32'(busy),  32'h0);
        chk("b1_final",      32'(pdo),   32'h01);
        step(3'b000, 3'd0, 1'b0, 1'b0, 8'h00);
        chk("b1_done_fall",  32'(done),  32'h0);

        // Burst 0xFF aborted by reset after the third valid cycle
        step(3'b111, 3'd0, 1'b1, 1'b0, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            chk("abort_valid", 32'(valid), 32'h1);
            chk("abort_sdo",   32'(sdo),   32'h1);
            step(3'b000, 3'd0, 1'b1, 1'b0, 8'h00);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_pdo",   32'(pdo),   32'h0);
        chk("abort_valid0", 32'(valid), 32'h0);
        chk("abort_sdo0",  32'(sdo),   32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_done", 32'(done), 32'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_done_rel", 32'(done), 32'h0);
        chk("abort_busy_rel", 32'(busy), 32'h0);

        // Back-to-back bursts 0x0F then 0xF0
        w = 8'h0F;
        for (int k = 0; k < WIDTH; k++) bit_q.push_back(w[k]);
        w = 8'hF0;
        for (int k = 0; k < WIDTH; k++) bit_q.push_back(w[k]);
        step(3'b111, 3'd0, 1'b0, 1'b0, 8'h0F);
        for (int k = 0; k < 2 * WIDTH; k++) begin
            chk("bb_valid", 32'(valid), 32'h1);
            chk("bb_done",  32'(done),  (k == WIDTH) ? 32'h1 : 32'h0);
            pop_bit("bb_sdo");
            if (k == WIDTH - 1) step(3'b111, 3'd0, 1'b0, 1'b0, 8'hF0);
            else                step(3'b000, 3'd0, 1'b0, 1'b0, 8'h00);
        end
        chk("bb_done_end", 32'(done), 32'h1);
        chk("bb_busy_end", 32'(busy), 32'h0);
        chk("bb_final",    32'(pdo),  32'h01);
        chk("q_drained",   32'(exp_q.size() + bit_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
